img_ram_mp: RTL and testbench

Multi-read-port image RAM for the bilinear datapath: one write port and NRD independent synchronous read ports over a single logical DATA_W × 2^ADDR_W image buffer, so the four neighbour pixels of an interpolation window are fetched in one cycle. Each read port has its own request/valid pair. A hardware clear sequencer fills the buffer with a constant value between frames. The block sits between the pixel loader and the bilinear interpolation core.

---
 rtl/img_mem_pkg.sv | 25 ++
 rtl/img_ram_bank.sv | 32 +++
 rtl/img_ram_mp.sv | 138 +++++++++++++
 tb/tb_img_ram_mp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_mem_pkg.sv
// Shared types and helpers for the multi-read-port image RAM.
// Holds the clear-sequencer state encoding, default geometry and flat-bus slicing.
package img_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 12;
    localparam int NRD_DEF    = 4;

    // Widest flat per-port bus the slicing helper accepts.
    localparam int SLICE_BUS_W = 1024;

    // Returns field idx (each w bits wide, w < 32) of a flat per-port bus.
    function automatic logic [31:0] bus_slice(input logic [SLICE_BUS_W-1:0] bus,
                                              input int idx,
                                              input int w);
        return 32'(bus >> (idx * w)) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/img_ram_bank.sv
// 1W1R synchronous RAM replica; the read register loads only on re and holds otherwise.
// Same-address read and write in one cycle returns the old word.
module img_ram_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q_reg <= mem[raddr];
        end
    end

    assign rdata = q_reg;

endmodule

// File: rtl/img_ram_mp.sv
// Image buffer with one write port, NRD read ports and a hardware clear sequencer.
// Optional macro IMG_RAM_RDW_FWD_EN forwards same-cycle write data to a colliding read.
module img_ram_mp
    import img_mem_pkg::*;
#(
    parameter int                 DATA_W  = DATA_W_DEF,
    parameter int                 ADDR_W  = ADDR_W_DEF,
    parameter int                 NRD     = NRD_DEF,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NRD-1:0]       rd_req,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]       rd_valid,
    input  logic                 clr_start,
    output logic                 busy,
    output logic                 clr_done
);

    clr_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic              user_we;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic              rd_open;
    logic [NRD-1:0]    rd_en;
    logic [NRD-1:0]    rd_valid_reg;
    logic [NRD-1:0]    have_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt_reg + ADDR_W'(1);
                if (&cnt_reg) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_done = (state_reg == DONE);

    // A clear request in IDLE takes priority over a coincident user write.
    assign user_we    = we && !rst && ((state_reg == DONE) || ((state_reg == IDLE) && !clr_start));
    assign bank_we    = user_we || (!rst && (state_reg == CLEAR));
    assign bank_waddr = (state_reg == CLEAR) ? cnt_reg : waddr;
    assign bank_wdata = (state_reg == CLEAR) ? CLR_VAL : wdata;

    assign rd_open = !rst && (state_reg != CLEAR);
    assign rd_en   = rd_open ? rd_req : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg  <= '0;
            have_data_reg <= '0;
        end else begin
            rd_valid_reg  <= rd_en;
            have_data_reg <= have_data_reg | rd_en;
        end
    end

    assign rd_valid = rd_valid_reg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            logic [ADDR_W-1:0] port_addr;
            logic [DATA_W-1:0] bank_q;
            logic [DATA_W-1:0] port_data;

            assign port_addr = ADDR_W'(bus_slice(SLICE_BUS_W'(raddr), gi, ADDR_W));

            img_ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we),
                .waddr (bank_waddr),
                .wdata (bank_wdata),
                .re    (rd_en[gi]),
                .raddr (port_addr),
                .rdata (bank_q)
            );

`ifdef IMG_RAM_RDW_FWD_EN
            logic              fwd_hit_reg;
            logic [DATA_W-1:0] fwd_data_reg;

            // Hit flag and data only move on an accepted read so a held result stays put.
            always_ff @(posedge clk) begin
                if (rst) begin
                    fwd_hit_reg  <= 1'b0;
                    fwd_data_reg <= '0;
                end else if (rd_en[gi]) begin
                    fwd_hit_reg  <= user_we && (waddr == port_addr);
                    fwd_data_reg <= wdata;
                end
            end

            assign port_data = fwd_hit_reg ? fwd_data_reg : bank_q;
`else
            assign port_data = bank_q;
`endif

            // Until the first accepted read after reset the port presents zero.
            assign rdata[gi*DATA_W +: DATA_W] = have_data_reg[gi] ? port_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_img_ram_mp.sv
// Directed scoreboard bench for img_ram_mp: reads are predicted from a memory model
// when issued and checked against the DUT one cycle later.
module tb_img_ram_mp;

    localparam int              DW    = 8;
    localparam int              AW    = 7;
    localparam int              NP    = 4;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   CV    = 8'hFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NP-1:0]     rd_req;
    logic [NP*AW-1:0]  raddr;
    logic [NP*DW-1:0]  rdata;
    logic [NP-1:0]     rd_valid;
    logic              clr_start;
    logic              busy;
    logic              clr_done;

    always #5 clk = ~clk;

    img_ram_mp #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NRD     (NP),
        .CLR_VAL (CV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rd_req    (rd_req),
        .raddr     (raddr),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       sb[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] last_rd [NP];
    int            mst = 0;     // 0 idle, 1 clearing, 2 done
    int            mcnt = 0;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            busy_cycles = 0;
    int            done_pulses = 0;
    int            start_edge = 0;
    int            done_edge = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [NP-1:0] mask, input int a0, input int a1,
                          input int a2, input int a3);
        rd_req = mask;
        raddr  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Predict this edge from current inputs, advance one clock, then check outputs.
    task automatic step();
        logic [NP-1:0] m;
        logic          user_wr;
        logic [AW-1:0] pa;
        rd_exp_t       e;
        m       = (!rst && mst != 1) ? rd_req : '0;
        user_wr = we && !rst && (mst == 2 || (mst == 0 && !clr_start));
        for (int p = 0; p < NP; p++) begin
            if (m[p]) begin
                pa     = raddr[p*AW +: AW];
                e.port = p;
                e.addr = pa;
                e.data = model_mem[pa];
`ifdef IMG_RAM_RDW_FWD_EN
                if (user_wr && waddr == pa) e.data = wdata;
`endif
                sb.push_back(e);
            end
        end
        if (rst) begin
            mst  = 0;
            mcnt = 0;
        end else begin
            case (mst)
                0: if (clr_start) begin
                    mst        = 1;
                    mcnt       = 0;
                    start_edge = cyc + 1;
                end
                1: begin
                    model_mem[mcnt] = CV;
                    if (mcnt == DEPTH - 1) mst = 2;
                    mcnt = (mcnt + 1) % DEPTH;
                end
                default: mst = 0;
            endcase
        end
        if (user_wr) begin
            model_mem[waddr] = wdata;
            $display("wr addr 0x%02h data 0x%02h", waddr, wdata);
        end

        @(posedge clk);
        #1;
        cyc++;

        if (rst) begin
            for (int p = 0; p < NP; p++) last_rd[p] = '0;
        end
        chk("rd_valid", 32'(rd_valid), 32'(m));
        chk("busy", 32'(busy), 32'(mst == 1));
        chk("clr_done", 32'(clr_done), 32'(mst == 2));
        if (busy) busy_cycles++;
        if (clr_done) begin
            done_pulses++;
            done_edge = cyc;
        end
        for (int p = 0; p < NP; p++) begin
            if (m[p]) begin
                e = sb.pop_front();
                chk("sb_port", 32'(p), 32'(e.port));
                chk("rdata", 32'(rdata[p*DW +: DW]), 32'(e.data));
                last_rd[p] = e.data;
                $display("rd port %0d addr 0x%02h data 0x%02h exp 0x%02h",
                         p, e.addr, rdata[p*DW +: DW], e.data);
            end else begin
                chk("rdata_hold", 32'(rdata[p*DW +: DW]), 32'(last_rd[p]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; clr_start = 1'b0; waddr = '0; wdata = '0;
        set_rd('0, 0, 0, 0, 0);
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Clear with a coincident write, then write/read traffic throughout.
        clr_start = 1'b1; we = 1'b1; waddr = AW'(3); wdata = 8'h99;
        set_rd('1, 3, 3, 3, 3);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            clr_start = (i == 10);
            we        = 1'b1;
            waddr     = AW'($urandom_range(0, DEPTH - 1));
            wdata     = DW'($urandom);
            set_rd('1, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                   $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            step();
        end
        clr_start = 1'b0; we = 1'b0;
        step();
        set_rd('0, 0, 0, 0, 0);
        step();
        chk("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
        chk("done_pulses", 32'(done_pulses), 32'd1);
        chk("done_latency", 32'(done_edge - start_edge), 32'(DEPTH));

        for (int a = 0; a < DEPTH; a += 4) begin
            set_rd('1, a, a + 1, a + 2, a + 3);
            step();
        end
        set_rd('1, 3, 0, DEPTH - 1, 3);
        step();
        chk("addr3_cleared", 32'(rdata[DW-1:0]), 32'(CV));

        // Single write broadcast to all ports, then a hold cycle.
        set_rd('0, 0, 0, 0, 0);
        we = 1'b1; waddr = AW'(16); wdata = 8'h5A;
        step();
        we = 1'b0;
        set_rd('1, 16, 16, 16, 16);
        step();
        chk("bcast_valid", 32'(rd_valid), 32'hF);
        chk("bcast_data", 32'(rdata), 32'h5A5A5A5A);
        set_rd('0, 0, 0, 0, 0);
        step();

        // Distinct per-port data.
        we = 1'b1;
        waddr = AW'(0);  wdata = 8'h11; step();
        waddr = AW'(1);  wdata = 8'h22; step();
        waddr = AW'(64); wdata = 8'h33; step();
        waddr = AW'(65); wdata = 8'h44; step();
        we = 1'b0;
        set_rd('1, 0, 1, 64, 65);
        step();
        chk("xport_data", 32'(rdata), 32'h44332211);

        // Read during write to the same address.
        we = 1'b1; waddr = AW'(32); wdata = 8'h07;
        set_rd('0, 0, 0, 0, 0);
        step();
        wdata = 8'hAB;
        set_rd('1, 32, 16, 32, 65);
        step();
        we = 1'b0;
        set_rd(4'b0001, 32, 0, 0, 0);
        step();
        chk("rdw_after", 32'(rdata[DW-1:0]), 32'hAB);
        set_rd('0, 0, 0, 0, 0);
        step();

        // Reset five cycles into a clear.
        we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            waddr = AW'(i);
            wdata = DW'(8'h30 + i);
            step();
        end
        we = 1'b0;
        done_pulses = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("abort_no_done", 32'(done_pulses), 32'd0);
        set_rd('1, 0, 1, 2, 3);
        step();
        set_rd('1, 4, 5, 6, 7);
        step();
        chk("abort_addr5", 32'(rdata[2*DW-1:DW]), 32'h35);
        set_rd(4'b0011, 8, 9, 0, 0);
        step();
        set_rd('0, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
